// File: rtl/ramfill_pkg.sv
// ============================================================================
// Module      : ramfill_pkg
// Description : Shared FSM state encoding and circular-address helper for
//               the triggered capture buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ramfill_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ARMED     = 3'd1;
  localparam logic [2:0] WAIT_TRIG = 3'd2;
  localparam logic [2:0] POST      = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  // (a + b) mod depth, valid when both operands are already below depth
  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned depth);
    int unsigned s;
    s = a + b;
    return (s >= depth) ? (s - depth) : s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ramfill_ram.sv
// ============================================================================
// Module      : ramfill_ram
// Description : Simple dual-port RAM, synchronous write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ramfill_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 160,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/ramfill_trig.sv
// ============================================================================
// Module      : ramfill_trig
// Description : Triggered ADC capture buffer with pre-trigger history and a
//               time-ordered read port. Optional input decimation is enabled
//               by defining RAMFILL_DECIM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ramfill_trig
  import ramfill_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 160,
  parameter int PRETRIG = 40,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk_adc,
  input  logic              reset,
  input  logic              enable,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  input  logic              force_trig,
`ifdef RAMFILL_DECIM_EN
  input  logic [3:0]        decim,
`endif
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              finished
);

  localparam int              POST_N  = DEPTH - PRETRIG;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PRE_X   = (ADDR_W+1)'(PRETRIG);
  localparam logic [ADDR_W:0] POST_X  = (ADDR_W+1)'(POST_N);
  localparam logic [ADDR_W:0] ONE_X   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] wr_next;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_inc;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              force_pend;
  logic              accept;
  logic              arm;
  logic              we;
  logic              rise_hit;
  logic              fall_hit;
  logic              hit;

  assign arm     = enable && (state == IDLE || state == DONE);
  assign wr_next = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
  assign cnt_inc = cnt + ONE_X;

`ifdef RAMFILL_DECIM_EN
  logic [14:0] dec_cnt;
  logic [14:0] dec_max;

  assign dec_max = 15'((16'd1 << decim) - 16'd1);
  assign accept  = adc_valid && (dec_cnt == '0);

  always_ff @(posedge clk_adc) begin
    if (reset || arm) begin
      dec_cnt <= '0;
    end else if (adc_valid) begin
      dec_cnt <= (dec_cnt >= dec_max) ? '0 : dec_cnt + 15'd1;
    end
  end
`else
  assign accept = adc_valid;
`endif

  assign rise_hit = (prev < trig_level) && (adc_data >= trig_level);
  assign fall_hit = (prev > trig_level) && (adc_data <= trig_level);
  assign hit      = force_trig || force_pend ||
                    (prev_valid && (trig_rising ? rise_hit : fall_hit));

  // With no pre-trigger history ARMED is a pass-through state and never writes
  assign we = accept && (((PRETRIG > 0) && state == ARMED) ||
                         state == WAIT_TRIG || state == POST);

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      cnt        <= '0;
      start_addr <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      force_pend <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr <= wr_next;
      end
      case (state)
        IDLE, DONE: begin
          if (enable) begin
            state      <= ARMED;
            wr_ptr     <= '0;
            cnt        <= '0;
            prev_valid <= 1'b0;
            force_pend <= 1'b0;
          end
        end
        ARMED: begin
          if (PRETRIG == 0) begin
            state <= WAIT_TRIG;
          end else if (accept) begin
            cnt        <= cnt_inc;
            prev       <= adc_data;
            prev_valid <= 1'b1;
            if (cnt_inc == PRE_X) begin
              state <= WAIT_TRIG;
            end
          end
        end
        WAIT_TRIG: begin
          if (force_trig && !accept) begin
            force_pend <= 1'b1;
          end
          if (accept) begin
            prev       <= adc_data;
            prev_valid <= 1'b1;
            if (hit) begin
              start_addr <= ADDR_W'(wrap_add(32'(wr_ptr), 32'(DEPTH - PRETRIG), 32'(DEPTH)));
              force_pend <= 1'b0;
              cnt        <= ONE_X;
              state      <= (POST_N == 1) ? DONE : POST;
            end
          end
        end
        POST: begin
          if (accept) begin
            cnt <= cnt_inc;
            if (cnt_inc == POST_X) begin
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == ARMED) || (state == WAIT_TRIG) || (state == POST);
  assign finished = (state == DONE);

  logic [ADDR_W:0]   rd_sum;
  logic              rd_oob;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_q;
  logic              zero_q;

  assign rd_sum = {1'b0, rd_addr} + {1'b0, start_addr};
  assign rd_oob = ({1'b0, rd_addr} >= DEPTH_X);

  always_comb begin
    ram_rd_addr = '0;
    if (!rd_oob) begin
      if (rd_sum >= DEPTH_X) begin
        ram_rd_addr = ADDR_W'(rd_sum - DEPTH_X);
      end else begin
        ram_rd_addr = ADDR_W'(rd_sum);
      end
    end
  end

  // Out-of-range flag is registered alongside the RAM read so both line up
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= rd_oob;
    end
  end

  assign rd_data = zero_q ? '0 : ram_q;

  ramfill_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk_adc),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (adc_data),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_q)
  );

endmodule

`default_nettype wire

// File: tb/tb_ramfill_trig.sv
// ============================================================================
// Module      : tb_ramfill_trig
// Description : Self-checking bench for ramfill_trig against a sample-history
//               reference model. Decimation tests build with RAMFILL_DECIM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ramfill_trig;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 160;
  localparam int PRETRIG = 40;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int POST_N  = DEPTH - PRETRIG;

  logic              clk_adc = 1'b0;
  logic              reset;
  logic              enable;
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic [DATA_W-1:0] trig_level;
  logic              trig_rising;
  logic              force_trig;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              finished;
`ifdef RAMFILL_DECIM_EN
  logic [3:0]        decim;
  int                dec_pc;
`endif

  int vectors = 0;
  int errors  = 0;
  int q[$];
  int trig_idx;
  bit done;

  always #5 clk_adc = ~clk_adc;

  ramfill_trig #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .PRETRIG (PRETRIG),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk_adc     (clk_adc),
    .reset       (reset),
    .enable      (enable),
    .adc_valid   (adc_valid),
    .adc_data    (adc_data),
    .trig_level  (trig_level),
    .trig_rising (trig_rising),
    .force_trig  (force_trig),
`ifdef RAMFILL_DECIM_EN
    .decim       (decim),
`endif
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .finished    (finished)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_adc);
    #1;
  endtask

  function automatic int gen(input int mode, input int k);
    case (mode)
      0:       return k % 256;
      1:       return 128 + int'(100.0 * $sin(2.0 * 3.14159265 * real'(k) / 37.0));
      2:       return 50;
      3:       return int'($urandom_range(0, 255));
      default: return int'($urandom_range(0, 150));
    endcase
  endfunction

  function automatic bit crossed(input int p, input int c, input int lvl, input bit rise);
    return rise ? (p < lvl && c >= lvl) : (p > lvl && c <= lvl);
  endfunction

  task automatic arm();
    enable = 1'b1; adc_valid = 1'b0; force_trig = 1'b0;
    tick();
    enable = 1'b0;
    check("arm_busy", 32'(busy), 32'd1);
    check("arm_finished", 32'(finished), 32'd0);
    q.delete();
    trig_idx = -1;
`ifdef RAMFILL_DECIM_EN
    dec_pc = 0;
`endif
  endtask

  // Drives one capture; the model is the ordered list of accepted samples
  task automatic capture(input int mode, input int lvl, input bit rise, input int vpct,
                         input int force_at, input int en_at, input int rst_post);
    int k;
    int d;
    bit v;
    bit f;
    bit acc;
    k = 0;
    done = 1'b0;
    trig_level = DATA_W'(lvl);
    trig_rising = rise;
    arm();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      v = ($urandom_range(1, 100) <= vpct);
      d = gen(mode, k);
      f = v && (force_at >= 0) && (cyc >= force_at);
      adc_valid  = v;
      adc_data   = d[DATA_W-1:0];
      force_trig = f;
      enable     = (cyc == en_at);
      acc = v;
`ifdef RAMFILL_DECIM_EN
      if (v) begin
        acc = (dec_pc == 0);
        dec_pc = (dec_pc + 1) % (1 << decim);
      end
`endif
      if (acc) begin
        if (trig_idx < 0 && q.size() >= PRETRIG &&
            (f || (q.size() >= 1 && crossed(q[$], d, lvl, rise))))
          trig_idx = q.size();
        q.push_back(d);
      end
      if (v) k++;
      tick();
      if (rst_post >= 0 && trig_idx >= 0 && q.size() >= trig_idx + rst_post) begin
        check("post_busy", 32'(busy), 32'd1);
        reset = 1'b1; adc_valid = 1'b0; force_trig = 1'b0; enable = 1'b0;
        tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_finished", 32'(finished), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        return;
      end
      if (finished) begin
        done = 1'b1;
        break;
      end
    end
    adc_valid = 1'b0; force_trig = 1'b0; enable = 1'b0;
    check("finished_seen", 32'(done), 32'd1);
    if (done) begin
      check("sample_count", 32'(q.size()), 32'(trig_idx + POST_N));
      check("busy_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic read_at(input int addr, input int exp, input string tag);
    rd_addr = ADDR_W'(addr);
    tick();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic readback(input string tag);
    int idx;
    int exp;
    for (int i = 0; i < DEPTH; i++) begin
      idx = trig_idx - PRETRIG + i;
      exp = (trig_idx >= 0 && idx >= 0 && idx < q.size()) ? q[idx] : -1;
      read_at(i, exp, tag);
    end
  endtask

  initial begin
    int lvl;
    bit rise;
    int a;
    int b;
    reset = 1'b1; enable = 1'b0; adc_valid = 1'b0; adc_data = '0;
    trig_level = '0; trig_rising = 1'b1; force_trig = 1'b0; rd_addr = '0;
    trig_idx = -1;
`ifdef RAMFILL_DECIM_EN
    decim = 4'd0; dec_pc = 0;
`endif
    repeat (3) tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_finished", 32'(finished), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;

    // Ramp, rising through 100
    capture(0, 100, 1'b1, 100, -1, -1, -1);
    readback("ramp_trace");
    read_at(40, 100, "ramp_idx40");
    read_at(0, 60, "ramp_idx0");
    read_at(159, 219, "ramp_idx159");
    read_at(160, 0, "rd_oob160");
    read_at(200, 0, "rd_oob200");

    // Sine, falling through 128
    capture(1, 128, 1'b0, 100, -1, -1, -1);
    readback("sine_trace");
    rd_addr = ADDR_W'(PRETRIG); tick();
    check("sine_trig_le", 32'(rd_data <= 8'd128), 32'd1);
    rd_addr = ADDR_W'(PRETRIG - 1); tick();
    check("sine_prev_gt", 32'(rd_data > 8'd128), 32'd1);

    // Constant below level, forced after a full wrap
    capture(2, 100, 1'b1, 100, 300, -1, -1);
    for (int i = 0; i < DEPTH; i++) read_at(i, 50, "const_trace");

    // Reset during POST, then a normal random capture
    lvl = int'($urandom_range(60, 200)); rise = 1'($urandom_range(0, 1));
    capture(3, lvl, rise, 100, 200, -1, 10);
    lvl = int'($urandom_range(60, 200)); rise = 1'($urandom_range(0, 1));
    capture(3, lvl, rise, 100, 250, -1, -1);
    readback("rand_trace");

    // 50% valid, enable pulsed while waiting for the forced trigger
    capture(4, 200, 1'b1, 50, 250, 150, -1);
    readback("stall_trace");

    // Random level/edge with stalls
    for (int r = 0; r < 2; r++) begin
      lvl = int'($urandom_range(20, 235)); rise = 1'($urandom_range(0, 1));
      capture(3, lvl, rise, 50, 600, -1, -1);
      readback("rand_stall_trace");
    end

`ifdef RAMFILL_DECIM_EN
    decim = 4'd2;
    capture(0, 100, 1'b1, 100, -1, -1, -1);
    readback("decim_trace");
    for (int i = 0; i < 8; i++) begin
      rd_addr = ADDR_W'(i); tick(); a = int'(rd_data);
      rd_addr = ADDR_W'(i + 1); tick(); b = int'(rd_data);
      check("decim_step", 32'((b - a + 256) % 256), 32'd4);
    end
    read_at(160, 0, "decim_oob");
    decim = 4'd0;
`else
    a = 0; b = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
